// File: rtl/shacc_mult_ctrl.sv
// shacc_mult_ctrl: sequential controller for the 16-bit shift-add multiplier.
// Latches a/b on an accepted start, runs one shift-add step per clock and
// presents a truncated 16-bit product with a sticky overflow flag and a
// one-cycle done pulse.
// Optional feature: define SHACC_EARLY_DONE_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (product and ovf are unchanged).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; product/ovf hold the last result
// RUN   | one shift-add iteration per cycle, busy=1
// DONE  | done=1 for one cycle; a start here is accepted like IDLE
module shacc_mult_ctrl #(
  parameter int ITERS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiplier bits above ITERS are never processed, so they are cleared at load.
  localparam logic [16:0] MASK17   = (17'd1 << ITERS) - 17'd1;
  localparam logic [15:0] B_MASK   = MASK17[15:0];
  localparam logic [4:0]  CNT_LAST = 5'(ITERS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] acc;
  logic [15:0] sh1;
  logic [15:0] sh2;
  logic [4:0]  cnt;
  logic        ovf_r;
  logic        load;
  logic [16:0] sum;
  logic [15:0] sh2_shift;
  logic        last_iter;

  // Iteration arithmetic and the RUN exit condition.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, sh1};
    sh2_shift = {1'b0, sh2[15:1]};
`ifdef SHACC_EARLY_DONE_EN
    last_iter = (cnt == CNT_LAST) || (sh2_shift == 16'd0);
`else
    last_iter = (cnt == CNT_LAST);
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and operand-load decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add datapath: load on accepted start, iterate while in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= 16'd0;
      sh1   <= 16'd0;
      sh2   <= 16'd0;
      cnt   <= 5'd0;
      ovf_r <= 1'b0;
    end else if (load) begin
      acc   <= 16'd0;
      sh1   <= a;
      sh2   <= b & B_MASK;
      cnt   <= 5'd0;
      ovf_r <= 1'b0;
    end else if (state == RUN) begin
      if (sh2[0]) begin
        acc <= sum[15:0];
      end
      sh1 <= {sh1[14:0], 1'b0};
      sh2 <= sh2_shift;
      cnt <= cnt + 5'd1;
      // A carry out of the add, or dropping a multiplicand bit that a
      // remaining multiplier bit would still use, means the true product
      // does not fit in 16 bits.
      if ((sh2[0] && sum[16]) || (sh1[15] && (sh2_shift != 16'd0))) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Outputs decode straight from registers.
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    product = acc;
    ovf     = ovf_r;
  end

endmodule

// File: tb/tb_shacc_mult_ctrl.sv
// Self-checking bench for shacc_mult_ctrl: a default (ITERS=16) instance and
// an ITERS=8 instance, checked against an arithmetic reference through a
// scoreboard queue. Honours SHACC_EARLY_DONE_EN when computing latency.
module tb_shacc_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start,  start8;
  logic [15:0] a, b, a8, b8;
  logic        busy, done, busy8, done8, ovf, ovf8;
  logic [15:0] product, product8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] p;
    logic        o;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  shacc_mult_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .ovf(ovf)
  );

  shacc_mult_ctrl #(.ITERS(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8), .ovf(ovf8)
  );

  function automatic int exp_lat(input logic [15:0] bm, input int iters);
    int h;
`ifdef SHACC_EARLY_DONE_EN
    h = 0;
    for (int i = 0; i < 16; i++) if (bm[i]) h = i + 1;
    if (h == 0) h = 1;
    return h + 1;
`else
    h = iters;
    return h + 1;
`endif
  endfunction

  function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi, input int iters);
    logic [16:0] m17;
    logic [15:0] bm;
    logic [31:0] full;
    exp_t        e;
    m17    = (17'd1 << iters) - 17'd1;
    bm     = bi & m17[15:0];
    full   = {16'd0, ai} * {16'd0, bm};
    e.p    = full[15:0];
    e.o    = |full[31:16];
    e.lat  = exp_lat(bm, iters);
    return e;
  endfunction

  // Push the expected result and drive a one-cycle start request.
  task automatic issue(input logic [15:0] ai, input logic [15:0] bi, input bit use8);
    sbq.push_back(model(ai, bi, use8 ? 8 : 16));
    @(negedge clk);
    if (use8) begin
      a8 = ai; b8 = bi; start8 = 1'b1;
    end else begin
      a = ai; b = bi; start = 1'b1;
    end
  endtask

  // Wait for done; lat counts negedges after the start cycle, -1 on timeout.
  task automatic wait_done(input bit use8, input int budget, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start  = 1'b0;
        start8 = 1'b0;
      end
      if (use8 ? busy8 : busy) bcnt++;
      if (use8 ? done8 : done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start8 = 1'b0;
    a = 16'd0; b = 16'd0; a8 = 16'd0; b8 = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if ({busy, done, ovf} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, ovf}); end
    total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product got=%h want=0000", product); end
    total++; if ({busy8, done8, ovf8, product8} !== 19'd0) begin bad++; $display("FAIL reset_dut8 got=%b/%h want=0/0000", {busy8, done8, ovf8}, product8); end
  endtask

  task automatic test_basic;
    int   lat, bc;
    exp_t x;
    issue(16'd3, 16'd5, 1'b0);
    wait_done(1'b0, 60, lat, bc);
    x = sbq.pop_front();
    total++; if (lat !== x.lat) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, x.lat); end
    total++; if (bc !== x.lat - 1) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, x.lat - 1); end
    total++; if (product !== x.p) begin bad++; $display("FAIL basic_product got=%h want=%h", product, x.p); end
    total++; if (ovf !== x.o) begin bad++; $display("FAIL basic_ovf got=%b want=%b", ovf, x.o); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL basic_single_pulse got=%b want=00", {busy, done}); end
    a = 16'hDEAD; b = 16'hBEEF;
    repeat (5) @(negedge clk);
    total++; if (product !== 16'h000F) begin bad++; $display("FAIL basic_hold got=%h want=000f", product); end
  endtask

  task automatic test_corners;
    logic [15:0] ca [3] = '{16'hFFFF, 16'h0100, 16'h8000};
    logic [15:0] cb [3] = '{16'h0001, 16'h0100, 16'h0001};
    int   lat, bc;
    exp_t x;
    for (int k = 0; k < 3; k++) begin
      issue(ca[k], cb[k], 1'b0);
      wait_done(1'b0, 60, lat, bc);
      x = sbq.pop_front();
      total++; if (lat !== x.lat) begin bad++; $display("FAIL corner%0d_latency got=%0d want=%0d", k, lat, x.lat); end
      total++; if (product !== x.p) begin bad++; $display("FAIL corner%0d_product got=%h want=%h", k, product, x.p); end
      total++; if (ovf !== x.o) begin bad++; $display("FAIL corner%0d_ovf got=%b want=%b", k, ovf, x.o); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t x;
    int   nd;
    bit   prev_done;
    sbq.delete();
    nd = 0;
    prev_done = 1'b0;
    @(negedge clk);
    a = 16'd2; b = 16'd7; start = 1'b1;
    x = model(16'd2, 16'd7, 16);
    sbq.push_back(x);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      total++; if ((busy && done) || (prev_done && done)) begin bad++; $display("FAIL b2b_pulse_shape cycle=%0d busy=%b done=%b prev_done=%b", i, busy, done, prev_done); end
      prev_done = done;
      if (done) begin
        nd++;
        if (sbq.size() == 0) begin
          total++; bad++; $display("FAIL b2b_unexpected_done cycle=%0d", i);
        end else begin
          x = sbq.pop_front();
          total++; if (i !== x.lat) begin bad++; $display("FAIL b2b_done_cycle got=%0d want=%0d", i, x.lat); end
          total++; if ({ovf, product} !== {x.o, x.p}) begin bad++; $display("FAIL b2b_product got=%b/%h want=%b/%h", ovf, product, x.o, x.p); end
        end
      end
      if (i < 40) begin
        start = 1'b1;
        if (done) begin
          a = 16'd2; b = 16'd7;
          x = model(16'd2, 16'd7, 16);
          x.lat += i;
          sbq.push_back(x);
        end else begin
          a = 16'($urandom); b = 16'($urandom);
        end
      end else begin
        start = 1'b0;
        if (sbq.size() == 0) break;
      end
    end
    start = 1'b0;
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL b2b_timeout pending=%0d want=0", sbq.size()); end
    total++; if (nd < 2) begin bad++; $display("FAIL b2b_done_count got=%0d want>=2", nd); end
    sbq.delete();
  endtask

  task automatic test_reset_abort;
    int   lat, bc;
    bit   saw;
    exp_t x;
    saw = 1'b0;
    @(negedge clk);
    a = 16'd3; b = 16'hFFFF; start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) saw = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    if (done) saw = 1'b1;
    reset = 1'b0;
    total++; if ({busy, done, ovf, product} !== 19'd0) begin bad++; $display("FAIL abort_cleared got=%b%b%b/%h want=000/0000", busy, done, ovf, product); end
    repeat (20) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", saw); end
    issue(16'd4, 16'd4, 1'b0);
    wait_done(1'b0, 60, lat, bc);
    x = sbq.pop_front();
    total++; if (lat !== x.lat) begin bad++; $display("FAIL abort_restart_latency got=%0d want=%0d", lat, x.lat); end
    total++; if (product !== x.p) begin bad++; $display("FAIL abort_restart_product got=%h want=%h", product, x.p); end
  endtask

  task automatic test_early;
    logic [15:0] ea [2] = '{16'd9, 16'd5};
    logic [15:0] eb [2] = '{16'd2, 16'd0};
    int   lat, bc;
    exp_t x;
    for (int k = 0; k < 2; k++) begin
      issue(ea[k], eb[k], 1'b0);
      wait_done(1'b0, 60, lat, bc);
      x = sbq.pop_front();
      total++; if (lat !== x.lat) begin bad++; $display("FAIL early%0d_latency got=%0d want=%0d", k, lat, x.lat); end
      total++; if ({ovf, product} !== {x.o, x.p}) begin bad++; $display("FAIL early%0d_product got=%b/%h want=%b/%h", k, ovf, product, x.o, x.p); end
    end
  endtask

  task automatic test_iters8;
    int   lat, bc;
    exp_t x;
    issue(16'd1, 16'h0103, 1'b1);
    wait_done(1'b1, 40, lat, bc);
    x = sbq.pop_front();
    total++; if (lat !== x.lat) begin bad++; $display("FAIL iters8_latency got=%0d want=%0d", lat, x.lat); end
    total++; if (product8 !== x.p) begin bad++; $display("FAIL iters8_product got=%h want=%h", product8, x.p); end
    total++; if (ovf8 !== x.o) begin bad++; $display("FAIL iters8_ovf got=%b want=%b", ovf8, x.o); end
  endtask

  task automatic test_random;
    int          lat, bc;
    bit          u8;
    logic [15:0] ra, rb;
    exp_t        x;
    for (int k = 0; k < 12; k++) begin
      u8 = (k >= 8);
      ra = 16'($urandom);
      rb = (k % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      issue(ra, rb, u8);
      wait_done(u8, 60, lat, bc);
      x = sbq.pop_front();
      total++; if (lat !== x.lat) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", k, lat, x.lat); end
      total++; if ((u8 ? {ovf8, product8} : {ovf, product}) !== {x.o, x.p}) begin
        bad++;
        $display("FAIL rand%0d_product a=%h b=%h got=%b/%h want=%b/%h", k, ra, rb,
                 u8 ? ovf8 : ovf, u8 ? product8 : product, x.o, x.p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_abort();
    test_early();
    test_iters8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
